// File: rtl/game_sequencer.sv
// game_sequencer: round life-cycle sequencer for the flappy-bird core.
// IDLE -> COUNT (countdown) -> PLAY -> OVER -> COUNT ... on the 100 ms tick.
// Drives core reset/run, latches the final score, tracks the session best
// and blinks a new-record indicator while the game-over scene is shown.
// Optional feature macro: GAME_SEQ_PAUSE_EN adds a PAUSE state toggled by
// rising edges of pause_btn while playing.
module game_sequencer #(
  parameter int COUNT_SEC     = 3,
  parameter int TICKS_PER_SEC = 10,
  parameter int OVER_HOLD     = 20,
  parameter int BLINK_TICKS   = 5
) (
  input  logic        clk_100ms,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        fail_in,
  input  logic [15:0] score_in,
  output logic [2:0]  state,
  output logic        core_rst_n,
  output logic        core_run,
  output logic [1:0]  countdown,
  output logic [15:0] final_score,
  output logic [15:0] high_score,
  output logic        new_record,
  output logic        blink
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_OVER  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;

  localparam int TW = $clog2(TICKS_PER_SEC + 1);
  localparam int HW = $clog2(OVER_HOLD + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  logic [TW-1:0] tick_cnt;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;

  // The lock bit is set by reset and only clears once the button is seen
  // low, so a button held through reset never produces a spurious edge.
  logic start_q, start_lock, start_edge;
  assign start_edge = start_btn & ~start_q & ~start_lock;

  // Start button history and post-reset lock.
  always_ff @(posedge clk_100ms) begin
    if (!rst) begin
      start_q    <= 1'b0;
      start_lock <= 1'b1;
    end else begin
      start_q    <= start_btn;
      start_lock <= start_lock & start_btn;
    end
  end

`ifdef GAME_SEQ_PAUSE_EN
  logic pause_q, pause_lock, pause_edge;
  assign pause_edge = pause_btn & ~pause_q & ~pause_lock;

  // Pause button history and post-reset lock.
  always_ff @(posedge clk_100ms) begin
    if (!rst) begin
      pause_q    <= 1'b0;
      pause_lock <= 1'b1;
    end else begin
      pause_q    <= pause_btn;
      pause_lock <= pause_lock & pause_btn;
    end
  end
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
`endif

  // Round FSM; core_rst_n/core_run are written alongside each state change
  // so they always describe the state being entered.
  always_ff @(posedge clk_100ms) begin
    if (!rst) begin
      state       <= S_IDLE;
      core_rst_n  <= 1'b0;
      core_run    <= 1'b0;
      countdown   <= '0;
      final_score <= '0;
      high_score  <= '0;
      new_record  <= 1'b0;
      blink       <= 1'b0;
      tick_cnt    <= '0;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state     <= S_COUNT;
            countdown <= 2'(COUNT_SEC);
            tick_cnt  <= TW'(TICKS_PER_SEC - 1);
          end
        end
        S_COUNT: begin
          if (tick_cnt == '0) begin
            if (countdown == 2'd1) begin
              state      <= S_PLAY;
              countdown  <= '0;
              core_rst_n <= 1'b1;
              core_run   <= 1'b1;
            end else begin
              countdown <= countdown - 2'd1;
              tick_cnt  <= TW'(TICKS_PER_SEC - 1);
            end
          end else begin
            tick_cnt <= tick_cnt - TW'(1);
          end
        end
        S_PLAY: begin
          // A crash wins over a simultaneous pause request.
          if (fail_in) begin
            state       <= S_OVER;
            core_run    <= 1'b0;
            final_score <= score_in;
            hold_cnt    <= HW'(OVER_HOLD);
            blink_cnt   <= '0;
            blink       <= 1'b0;
            if (score_in > high_score) begin
              high_score <= score_in;
              new_record <= 1'b1;
            end else begin
              new_record <= 1'b0;
            end
          end
`ifdef GAME_SEQ_PAUSE_EN
          else if (pause_edge) begin
            state    <= S_PAUSE;
            core_run <= 1'b0;
          end
`endif
        end
        S_OVER: begin
          // Early start presses are dropped, not remembered.
          if (start_edge && hold_cnt == '0) begin
            state      <= S_COUNT;
            core_rst_n <= 1'b0;
            countdown  <= 2'(COUNT_SEC);
            tick_cnt   <= TW'(TICKS_PER_SEC - 1);
            new_record <= 1'b0;
            blink      <= 1'b0;
            blink_cnt  <= '0;
          end else begin
            if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
            if (new_record) begin
              if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink     <= ~blink;
                blink_cnt <= '0;
              end else begin
                blink_cnt <= blink_cnt + BW'(1);
              end
            end
          end
        end
`ifdef GAME_SEQ_PAUSE_EN
        S_PAUSE: begin
          if (pause_edge) begin
            state    <= S_PLAY;
            core_run <= 1'b1;
          end
        end
`endif
        default: begin
          state      <= S_IDLE;
          core_rst_n <= 1'b0;
          core_run   <= 1'b0;
          countdown  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed round scenarios followed by random stimulus,
// every tick compared against a behavioural model built on "ticks spent in
// the current phase" arithmetic.
module tb_game_sequencer;
  localparam int COUNT_SEC = 3, TPS = 10, OVER_HOLD = 20, BLINK = 5;
  localparam int S_IDLE = 0, S_COUNT = 1, S_PLAY = 2, S_OVER = 3, S_PAUSE = 4;
`ifdef GAME_SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic        clk_100ms = 1'b0;
  logic        rst = 1'b0, start_btn = 1'b0, pause_btn = 1'b0, fail_in = 1'b0;
  logic [15:0] score_in = '0;
  logic [2:0]  state;
  logic        core_rst_n, core_run, new_record, blink;
  logic [1:0]  countdown;
  logic [15:0] final_score, high_score;

  int n_cmp = 0, n_bad = 0;

  // Reference model: phase + ticks spent in that phase.
  int          m_st = S_IDLE, m_age = 0;
  bit          m_sprev = 1'b1, m_pprev = 1'b1, m_rec = 1'b0;
  logic [15:0] m_final = '0, m_high = '0;

  always #5 clk_100ms = ~clk_100ms;

  game_sequencer dut (
    .clk_100ms(clk_100ms), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
    .fail_in(fail_in), .score_in(score_in), .state(state), .core_rst_n(core_rst_n),
    .core_run(core_run), .countdown(countdown), .final_score(final_score),
    .high_score(high_score), .new_record(new_record), .blink(blink)
  );

  task automatic model_step();
    bit s_e, p_e;
    if (!rst) begin
      // A button already held when reset releases must be let go first.
      m_st = S_IDLE; m_age = 0; m_sprev = 1'b1; m_pprev = 1'b1;
      m_rec = 1'b0; m_final = '0; m_high = '0;
      return;
    end
    s_e = start_btn && !m_sprev;
    p_e = pause_btn && !m_pprev;
    m_sprev = start_btn;
    m_pprev = pause_btn;
    case (m_st)
      S_IDLE: if (s_e) begin m_st = S_COUNT; m_age = 0; end
      S_COUNT: begin
        m_age++;
        if (m_age == COUNT_SEC * TPS) begin m_st = S_PLAY; m_age = 0; end
      end
      S_PLAY: begin
        if (fail_in) begin
          m_st = S_OVER; m_age = 0; m_final = score_in;
          m_rec = (score_in > m_high);
          if (m_rec) m_high = score_in;
        end else if (PAUSE_EN && p_e) m_st = S_PAUSE;
      end
      S_OVER: begin
        if (s_e && m_age >= OVER_HOLD) begin m_st = S_COUNT; m_age = 0; m_rec = 1'b0; end
        else m_age++;
      end
      default: if (p_e) m_st = S_PLAY;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int exp_cd;
    bit exp_blink;
    exp_cd    = (m_st == S_COUNT) ? COUNT_SEC - m_age / TPS : 0;
    exp_blink = (m_st == S_OVER) && m_rec && ((m_age / BLINK) % 2 == 1);
    chk("state", 32'(state), 32'(m_st));
    chk("core_rst_n", 32'(core_rst_n), 32'(m_st == S_PLAY || m_st == S_OVER || m_st == S_PAUSE));
    chk("core_run", 32'(core_run), 32'(m_st == S_PLAY));
    chk("countdown", 32'(countdown), 32'(exp_cd));
    chk("final_score", 32'(final_score), 32'(m_final));
    chk("high_score", 32'(high_score), 32'(m_high));
    chk("new_record", 32'(new_record), 32'(m_rec));
    chk("blink", 32'(blink), 32'(exp_blink));
  endtask

  task automatic tick();
    @(posedge clk_100ms);
    model_step();
    #1;
    check_all();
  endtask

  // From IDLE or OVER: wait out the hold, press start, run the countdown.
  task automatic to_play();
    while (m_st == S_OVER && m_age < OVER_HOLD) tick();
    start_btn = 1'b0; tick();
    start_btn = 1'b1; tick();
    start_btn = 1'b0;
    for (int i = 0; i < 40 && m_st != S_PLAY; i++) tick();
    chk("to_play", 32'(state), 32'(S_PLAY));
  endtask

  task automatic round(input logic [15:0] sc);
    to_play();
    repeat (2) tick();
    score_in = sc; fail_in = 1'b1; tick();
    fail_in = 1'b0;
  endtask

  initial begin
    int n;
    // 1: reset with start held, then release reset still holding start.
    rst = 1'b0; start_btn = 1'b1;
    tick(); tick();
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_high", 32'(high_score), 32'd0);
    rst = 1'b1;
    repeat (3) tick();
    chk("held_start_idle", 32'(state), 32'(S_IDLE));

    // 2: countdown 3,2,1 then PLAY after 30 ticks.
    start_btn = 1'b0; tick();
    start_btn = 1'b1; tick();
    start_btn = 1'b0;
    chk("enter_count", 32'(state), 32'(S_COUNT));
    chk("cd_first", 32'(countdown), 32'd3);
    n = 0;
    while (!core_run && n < 40) begin tick(); n++; end
    chk("count_len", 32'(n), 32'd30);

    // 3: crash with 7 -> record; blink every 5 ticks.
    repeat (3) tick();
    score_in = 16'd7; fail_in = 1'b1; tick();
    fail_in = 1'b0;
    chk("over_final", 32'(final_score), 32'd7);
    chk("over_high", 32'(high_score), 32'd7);
    chk("over_rec", 32'(new_record), 32'd1);
    repeat (4) tick();
    chk("blink_lo", 32'(blink), 32'd0);
    tick();
    chk("blink_hi", 32'(blink), 32'd1);
    repeat (5) tick();
    chk("blink_lo2", 32'(blink), 32'd0);

    // 5: early start dropped, accepted once the hold expires.
    start_btn = 1'b1; tick();
    start_btn = 1'b0;
    chk("early_start", 32'(state), 32'(S_OVER));
    while (m_age < OVER_HOLD) tick();
    start_btn = 1'b1; tick();
    start_btn = 1'b0;
    chk("restart", 32'(state), 32'(S_COUNT));
    chk("restart_rec", 32'(new_record), 32'd0);

    // 4: equal score is not a record; higher one is.
    repeat (30) tick();
    chk("play2", 32'(core_run), 32'd1);
    score_in = 16'd7; fail_in = 1'b1; tick();
    fail_in = 1'b0;
    chk("eq_rec", 32'(new_record), 32'd0);
    chk("eq_high", 32'(high_score), 32'd7);
    round(16'd9);
    chk("hi9", 32'(high_score), 32'd9);
    chk("hi9_rec", 32'(new_record), 32'd1);

    // 6: fail beats pause; pause toggling.
    to_play();
    pause_btn = 1'b1; fail_in = 1'b1; score_in = 16'd3; tick();
    pause_btn = 1'b0; fail_in = 1'b0;
    chk("fail_beats_pause", 32'(state), 32'(S_OVER));
    chk("fail_final", 32'(final_score), 32'd3);
    to_play();
    pause_btn = 1'b1; tick();
    chk("pause_in", 32'(state), PAUSE_EN ? 32'(S_PAUSE) : 32'(S_PLAY));
    fail_in = 1'b1; repeat (3) tick();
    chk("pause_fail", 32'(state), PAUSE_EN ? 32'(S_PAUSE) : 32'(S_OVER));
    fail_in = 1'b0; pause_btn = 1'b0; tick();
    pause_btn = 1'b1; tick();
    pause_btn = 1'b0;
    chk("pause_out", 32'(state), PAUSE_EN ? 32'(S_PLAY) : 32'(S_OVER));
    fail_in = 1'b1; tick();
    fail_in = 1'b0;
    chk("after_pause_over", 32'(state), 32'(S_OVER));

    // 7: reset during COUNT and during PLAY.
    while (m_age < OVER_HOLD) tick();
    start_btn = 1'b1; tick();
    start_btn = 1'b0;
    repeat (5) tick();
    rst = 1'b0; tick();
    rst = 1'b1;
    chk("rst_count_state", 32'(state), 32'(S_IDLE));
    chk("rst_count_high", 32'(high_score), 32'd0);
    tick();
    round(16'd20);
    chk("hi20", 32'(high_score), 32'd20);
    to_play();
    repeat (3) tick();
    score_in = 16'd50; rst = 1'b0; tick();
    rst = 1'b1;
    chk("rst_play_state", 32'(state), 32'(S_IDLE));
    chk("rst_play_high", 32'(high_score), 32'd0);
    chk("rst_play_final", 32'(final_score), 32'd0);

    // Random soak.
    repeat (3000) begin
      rst       = ($urandom_range(0, 99) != 0);
      start_btn = ($urandom_range(0, 5) == 0);
      pause_btn = ($urandom_range(0, 7) == 0);
      fail_in   = ($urandom_range(0, 19) == 0);
      score_in  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
